serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB digit first, using a chain of DIGIT full-adder cells and a registered carry.
- Uses a start/busy/done handshake, so it can sit behind a slow controller where area matters more than latency.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥2.
- DIGIT, 1: bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new operation; sampled only when busy=0.
- sub, input, 1: 0 = add, 1 = subtract; sampled with start.
- a_in, input, WIDTH: operand A; sampled with start.
- b_in, input, WIDTH: operand B; sampled with start.
- cin, input, 1: carry-in for add; ignored when sub=1; sampled with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when results update.
- sum_out, output, WIDTH: result; held until the next completion.
- cout, output, 1: carry out of the MSB. For subtract, 1 = no borrow.
- ovf, output, 1: two's-complement signed overflow of the result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum_out=0, cout=0, ovf=0; operand and shift registers and the digit counter cleared. Reset mid-operation abandons the operation; no done pulse is produced.
- States:
  - IDLE.
  - RUN: digit counter 0..N-1.
  - DONE: one cycle.
- IDLE/DONE with start=1 at an edge:
  - latch A=a_in and B'=(sub ? ~b_in : b_in);
  - carry register = (sub ? 1 : cin);
  - go to RUN with count=0; busy=1 from that edge.
- DONE with start=0: go to IDLE. This allows back-to-back operations with no idle gap.
- RUN, each edge:
  - Add DIGIT LSBs of A and B' plus the carry register through a DIGIT-cell ripple.
  - Shift the DIGIT sum bits into the MSB end of the internal result shift register.
  - Shift A and B' right by DIGIT; carry register takes the last cell's carry; count increments.
- RUN, edge with count=N-1:
  - sum_out ← final shifted result; cout ← MSB carry.
  - ovf ← (carry into MSB cell) XOR (carry out of MSB cell).
  - Go to DONE: done=1 and busy=0 for exactly that following cycle.
- Latency: start sampled at edge E; outputs valid and done=1 after edge E+N. With WIDTH=8, DIGIT=1, that is 8 edges.
- start while busy=1 is ignored; operands are not re-sampled. sub, a_in, b_in and cin may change freely while busy.
- sum_out, cout and ovf change only on the completion edge or on reset. They are never visible mid-computation.
- Wrap-around: the result is modulo 2^WIDTH; cout carries the lost bit.
- Subtract semantics: result = A − B mod 2^WIDTH; cout=1 iff A ≥ B unsigned.

Test Plan:
- WIDTH=8, DIGIT=1; start with a=200, b=100, cin=0, sub=0 → done exactly 8 edges after the start edge; sum_out=44, cout=1, ovf=0; busy high for 8 cycles, done high 1 cycle.
- a=127, b=1, cin=0, add → sum_out=128, cout=0, ovf=1. Then a=128, b=128 → sum_out=0, cout=1, ovf=1.
- Subtract:
  - a=5, b=7, sub=1 (cin=1 ignored) → sum_out=254, cout=0, ovf=0.
  - a=7, b=5 → sum_out=2, cout=1.
- Handshake: pulse start again mid-RUN with different operands → ignored; first result unchanged. Hold start high through DONE → second operation begins with no idle cycle.
- Reset: assert rst_n low at count=4 → all outputs 0 immediately (asynchronous), no done pulse; a new start after release completes normally.
- Exhaustive check:
  - WIDTH=4, DIGIT=2: all 2×2×256 combinations of sub, cin and (a, b) against a behavioural model of {cout, sum} and ovf; 0 errors; each operation done after 2 edges.
  - WIDTH=16, DIGIT=4: spot check a=0xFFFF, b=1, add → sum_out=0, cout=1, ovf=0, done after 4 edges.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus of serial_adder
// master drives start, sub, a_in, b_in, cin; slave drives busy, done, sum_out, cout, ovf
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start, sub, cin, busy, done, cout, ovf;
  logic [WIDTH-1:0] a_in, b_in, sum_out;
  modport master(output start, sub, a_in, b_in, cin, input busy, done, sum_out, cout, ovf);
  modport slave(input start, sub, a_in, b_in, cin, output busy, done, sum_out, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, DIGIT bits per clock, LSB digit first
// clk: rising-edge clock; rst_n: asynchronous active-low reset
// bus (slave): start/sub/a_in/b_in/cin in, busy/done/sum_out/cout/ovf out
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0] dsum;
  logic msb_cin;
  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // carry into the top cell of this digit, recovered from its sum bit
    msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q != RUN && bus.start) begin
      state_d = RUN;
      a_d = bus.a_in;
      b_d = bus.sub ? ~bus.b_in : bus.b_in;
      carry_d = bus.sub | bus.cin;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      res_d = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      carry_d = dsum[DIGIT];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        sum_d = res_d;
        cout_d = dsum[DIGIT];
        ovf_d = dsum[DIGIT] ^ msb_cin;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum_out = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule
